// File: rtl/fetch_sequencer_pkg.sv
// Shared types and sizes for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 32;
  localparam int QDEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO; the head register drives the decode-side outputs directly.
module fetch_queue
  import fetch_sequencer_pkg::*;
#(
  parameter int W = PC_W + INST_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] slot1;
  logic [1:0]   count;
  logic         do_pop;
  logic         do_push;

  assign full    = (count == 2'(QDEPTH));
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (empty) head <= din;
          else       slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // count stays put; a full queue shifts, a single entry is replaced
          if (full) begin
            head  <= slot1;
            slot1 <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a PC through the ROM into a 2-entry queue.
//   state  | meaning
//   IDLE   | after reset, no fetching until start
//   RUN    | fetching one word per edge while the queue has room
//   HALTED | fetching stopped by halt_req, resumes on start
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt_req,
  input  logic                redirect,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic [PC_W-1:0]     rom_addr,
  input  logic [INST_W-1:0]   rom_data,
  output logic [INST_W-1:0]   inst_out,
  output logic [PC_W-1:0]     inst_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic                busy,
  output logic [PC_W-1:0]     fetch_count
);

  state_t                   state;
  logic [PC_W-1:0]          pc;
  logic [PC_W+INST_W-1:0]   head;
  logic                     q_full;
  logic                     q_empty;
  logic                     pop;
  logic                     push;

  assign rom_addr            = pc;
  assign inst_valid          = !q_empty;
  assign {inst_pc, inst_out} = head;
  assign busy                = (state == RUN);

  assign pop  = inst_valid && inst_ready;
  assign push = (state == RUN) && !halt_req && !redirect && (!q_full || pop);

  fetch_queue u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({pc, rom_data}),
    .head  (head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      fetch_count <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else begin
      if (push) begin
        pc          <= pc + 16'd1;
        fetch_count <= fetch_count + 16'd1;
      end
      case (state)
        RUN:         if (halt_req) state <= HALTED;
        IDLE, HALTED: if (start && !halt_req) state <= RUN;
        default:     state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begin/resume fetching.
- halt_req, input, 1, stop issuing new fetches.
- redirect, input, 1, branch/flush request.
- redirect_pc, input, 16, new word address.
- rom_addr, output, 16, word address to the instruction ROM.
- rom_data, input, 32, combinational ROM word for rom_addr.
- inst_out, output, 32, head-of-queue instruction.
- inst_pc, output, 16, address of inst_out.
- inst_valid, output, 1, queue head valid.
- inst_ready, input, 1, decode accepts head.
- busy, output, 1, high in state RUN.
- fetch_count, output, 16, total pushes since reset.
REQ-002 SHALL have one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL hold a 16-bit PC register; rom_addr SHALL equal PC combinationally.
REQ-004 SHALL implement states IDLE, RUN and HALTED.
- IDLE->RUN on start.
- RUN->HALTED on halt_req.
- HALTED->RUN on start.
- halt_req has priority over start.
REQ-005 SHALL contain a 2-entry FIFO of {PC, rom_data}; inst_out and inst_pc SHALL come from its head register.
REQ-006 SHALL pop on an edge with inst_valid && inst_ready.
REQ-007 SHALL push in RUN when the queue is not full or a pop occurs the same edge; push+pop on a full queue SHALL keep count at 2.
REQ-008 SHALL increment PC by 1 on each push; 16'hFFFF SHALL wrap to 16'h0000.
REQ-009 SHALL increment fetch_count by 1 per push, wrapping at 16 bits.
REQ-010 SHALL make redirect highest priority in any state:
- empty the queue;
- load PC with redirect_pc;
- no push and no fetch_count change that edge;
- a concurrent pop is discarded;
- state unchanged.
REQ-011 SHALL give this latency: after redirect sampled at edge E0, the first entry with inst_pc==redirect_pc SHALL be pushed at E1, with inst_valid high after E1.
REQ-012 SHALL give this latency: start sampled in IDLE at E0 -> first push (PC 0) at E1 -> inst_valid high after E1.
REQ-013 SHALL not push from the edge on which halt_req is sampled; queued entries SHALL remain poppable in HALTED and IDLE.
REQ-014 SHALL keep inst_out, inst_pc and inst_valid stable while inst_valid && !inst_ready.
REQ-015 SHALL not interpret instruction contents (all branching via redirect).

Reset
REQ-016 SHALL, with reset high at an edge, set:
- state=IDLE;
- PC=16'h0000;
- queue empty;
- inst_valid=0, inst_out=0, inst_pc=0;
- fetch_count=0;
- busy=0.
REQ-017 SHALL give reset priority over redirect, start and halt_req.
REQ-018 SHALL discard in-flight queue contents when reset occurs mid-RUN.

Structure
REQ-019 SHALL place in a shared package:
- state enum (IDLE, RUN, HALTED);
- PC_W=16, INST_W=32, QDEPTH=2.
REQ-020 SHALL implement the FIFO as one sub-module fetch_queue (push, pop, flush, full, empty, head), instantiated once.
REQ-021 SHALL connect to the instruction ROM only via rom_addr and rom_data.

Verification
REQ-022 SHALL cover reset then start with inst_ready=1:
- inst_pc = 0,1,2,... on consecutive cycles;
- fetch_count=3 after three pushes.
REQ-023 SHALL cover backpressure, inst_ready=0 for 5 cycles after start:
- queue fills with PC 0,1;
- PC holds at 2;
- inst_out stable;
- on release, PCs 0,1,2 delivered in order with no loss or duplication.
REQ-024 SHALL cover redirect=1, redirect_pc=16'h000C with a full queue:
- inst_valid=0 on the next cycle;
- next delivered inst_pc=16'h000C with rom_data of address 12.
REQ-025 SHALL cover halt_req in RUN with inst_ready=0:
- busy drops;
- PC frozen;
- queued 2 entries still drain when ready rises;
- start resumes at the frozen PC.
REQ-026 SHALL cover redirect_pc=16'hFFFF in RUN:
- delivered PCs 16'hFFFF then 16'h0000.
REQ-027 SHALL cover reset asserted mid-RUN with full queue:
- next cycle inst_valid=0, PC=0, fetch_count=0, state IDLE.
